// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for serial_adder
// Purpose: FSM state encoding and counter-width helper used by serial_adder.
// Ports: none (package).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach steps-1; never narrower than 1 bit.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit full adder cell
// Purpose: one stage of the ripple chain inside serial_adder.
// Ports:
//   a, b  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle DIGIT-bits-per-clock adder/subtractor
// Purpose: adds/subtracts two WIDTH-bit operands LSB first, DIGIT bits per
//   clock, and reports sum, carry-out and signed overflow with a done pulse.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   start          - request; accepted in IDLE or DONE
//   a, b, cin, sub - operands, carry-in, subtract mode (captured on accept)
//   busy           - high while in RUN
//   done           - one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf - result, carry out of MSB, two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_s;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;

  // Ripple chain; w_c[DIGIT-1] is the carry into the top bit of this digit,
  // which on the last step is the carry into the operand MSB.
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (r_a[i]),
      .b  (r_b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // New sum digits enter at the top so after STEPS shifts the LSB digit
  // has travelled down to bit 0.
  if (STEPS == 1) begin : g_res_single
    assign w_res_next = w_s;
  end else begin : g_res_shift
    assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
  end

  assign w_accept = start && (r_state == IDLE || r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            // Subtract is a + ~b + 1, so the injected carry replaces cin.
            r_carry <= sub | cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c[DIGIT];
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_res_next;
            r_cout  <= w_c[DIGIT];
            r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT-1];
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin), .sub(sub),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Runs one 8-bit operation; optionally pulses start with a=b=1 when lat==poke.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                     input logic isub, input int poke, output logic [7:0] s,
                     output logic c, output logic o, output int lat, output int bcnt);
    @(negedge clk);
    a8 = ia; b8 = ib; cin = icin; sub = isub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      if (lat == poke) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    s = sum8; c = cout8; o = ovf8;
  endtask

  task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input string tag,
                      input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    int bcnt;
    @(negedge clk);
    a16 = ia; b16 = ib; cin = 1'b0; sub = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; lat = 0; bcnt = 0;
    while (!done16 && lat < 40) begin
      if (busy16) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_busy_cycles"}, bcnt, 4);
    chk({tag, "_sum"}, sum16, es);
    chk({tag, "_cout"}, cout16, ec);
    chk({tag, "_ovf"}, ovf16, eo);
  endtask

  initial begin
    logic [7:0] s;
    logic c, o;
    int lat, bcnt, t, held, dcount;

    vecs[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("reset_busy", {busy8, busy16}, 2'b00);
    chk("reset_done", {done8, done16}, 2'b00);
    chk("reset_sum8", sum8, 8'h00);
    chk("reset_sum16", sum16, 16'h0000);
    chk("reset_cout_ovf", {cout8, ovf8, cout16, ovf16}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven 8-bit vectors
    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, -1, s, c, o, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
    end

    // start re-asserted 3 cycles into RUN is ignored
    op8(8'h5A, 8'h33, 1'b0, 1'b0, 3, s, c, o, lat, bcnt);
    chk("poke_latency", lat, 8);
    chk("poke_sum", s, 8'h8D);
    chk("poke_cout_ovf", {c, o}, 2'b01);
    @(negedge clk);
    chk("poke_no_extra_op", {busy8, done8}, 2'b00);

    // Back-to-back: start held in the DONE cycle
    op8(8'h03, 8'h04, 1'b0, 1'b0, -1, s, c, o, lat, bcnt);
    chk("b2b_first_sum", s, 8'h07);
    a8 = 8'h10; b8 = 8'h20; cin = 1'b0; sub = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; t = 1; held = 1;
    while (!done8 && t < 40) begin
      if (sum8 !== 8'h07) held = 0;
      @(negedge clk);
      t++;
    end
    chk("b2b_done_spacing", t, 9);
    chk("b2b_sum_held", held, 1);
    chk("b2b_second_sum", sum8, 8'h30);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {busy8, done8}, 2'b00);
    chk("midrst_sum", sum8, 8'h00);
    chk("midrst_cout_ovf", {cout8, ovf8}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    op8(8'h12, 8'h34, 1'b0, 1'b0, -1, s, c, o, lat, bcnt);
    chk("postrst_latency", lat, 8);
    chk("postrst_sum", s, 8'h46);

    // WIDTH=16, DIGIT=4
    op16(16'h7FFF, 16'h0001, "w16_a", 16'h8000, 1'b0, 1'b1);
    op16(16'hFFFF, 16'h0001, "w16_b", 16'h0000, 1'b1, 1'b0);
    op16(16'h1234, 16'h4321, "w16_c", 16'h5555, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
